sram_dp_param: RTL and testbench

//   Parametrised single-port data SRAM for the AVR core data space. Maps a

---
 rtl/sram_dp_param.sv | 145 ++++++++++++++
 tb/tb_sram_dp_param.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_dp_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_dp_param
//   Data SRAM for the AVR core data space. Maps the address window
//   [BASE, BASE+DEPTH) onto a DEPTH-word array. Reads are registered (latency
//   1), writes take effect on the sampling edge, and an access outside the
//   window raises a one-cycle oor pulse. After every reset a clear sequencer
//   writes zero to each word, one per cycle, before ready goes high.
//
//   Optional feature macro: SRAM_PARITY_EN
//     defined   : each word carries an even-parity bit; in-range reads that
//                 find a mismatch pulse perr together with dout.
//     undefined : array is DW bits wide, perr is tied low.
//
// Ports
//   clk    in   1   clock, all logic on posedge
//   rst    in   1   synchronous reset, active-high
//   we     in   1   write request
//   re     in   1   read request
//   addr   in   AW  absolute data address
//   di     in   DW  write data
//   dout   out  DW  registered read data
//   ready  out  1   clear sequence finished, accesses accepted
//   oor    out  1   one-cycle pulse: previous access was outside the window
//   perr   out  1   one-cycle pulse: parity mismatch on read
// -----------------------------------------------------------------------------
module sram_dp_param #(
   parameter int DW    = 8,
   parameter int AW    = 12,
   parameter int BASE  = 256,
   parameter int DEPTH = 2048      // >= 2, BASE+DEPTH <= 2**AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] di,
   output logic [DW-1:0] dout,
   output logic          ready,
   output logic          oor,
   output logic          perr
);

   localparam int IW = $clog2(DEPTH);
`ifdef SRAM_PARITY_EN
   localparam int MW = DW + 1;
`else
   localparam int MW = DW;
`endif

   // Window bounds one bit wider than addr so BASE+DEPTH == 2**AW still fits.
   localparam logic [AW:0]   BASE_W   = (AW+1)'(BASE);
   localparam logic [AW:0]   LIMIT_W  = (AW+1)'(BASE + DEPTH);
   localparam logic [AW-1:0] BASE_A   = AW'(BASE);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   typedef enum logic {CLEAR, RUN} state_t;

   state_t          state;
   logic [IW-1:0]   clr_idx;
   logic [MW-1:0]   mem [DEPTH];

   logic            in_range;
   logic [IW-1:0]   idx;
   logic [MW-1:0]   di_word;
   logic [MW-1:0]   rd_word;
   logic            wr_en;
   logic [IW-1:0]   wr_idx;
   logic [MW-1:0]   wr_word;

   // Address decode and the single write port shared by the clear sequencer
   // and normal writes.
   // NOTE: every signal assigned here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      in_range = ({1'b0, addr} >= BASE_W) && ({1'b0, addr} < LIMIT_W);
      idx      = IW'(addr - BASE_A);
`ifdef SRAM_PARITY_EN
      di_word  = {^di, di};
`else
      di_word  = di;
`endif
      rd_word  = mem[idx];

      wr_en    = 1'b0;
      wr_idx   = clr_idx;
      wr_word  = '0;
      if (!rst) begin
         if (state == CLEAR) begin
            wr_en = 1'b1;
         end else if (we && in_range) begin
            wr_en   = 1'b1;
            wr_idx  = idx;
            wr_word = di_word;
         end
      end
   end

   // NOTE: the array has no reset branch; zeroing it is the clear sequencer's
   // job, which keeps the storage mappable onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_idx] <= wr_word;
   end

   // Control FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         clr_idx <= '0;
         ready   <= 1'b0;
         dout    <= '0;
         oor     <= 1'b0;
         perr    <= 1'b0;
      end else begin
         oor  <= 1'b0;
         perr <= 1'b0;
         if (state == CLEAR) begin
            // Requests are ignored here; dout holds and oor stays low.
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == LAST_IDX) begin
               state   <= RUN;
               ready   <= 1'b1;
               clr_idx <= '0;
            end
         end else begin
            oor <= (we || re) && !in_range;
            if (re) begin
               if (!in_range) begin
                  dout <= '0;
               end else if (we) begin
                  // Write-first: forward the incoming data, never a parity error.
                  dout <= di;
               end else begin
                  dout <= rd_word[DW-1:0];
`ifdef SRAM_PARITY_EN
                  perr <= ^rd_word;
`endif
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_dp_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_sram_dp_param
//   Self-checking bench for sram_dp_param. Directed scenarios plus randomized
//   traffic compared against an address-keyed reference memory.
// -----------------------------------------------------------------------------
module tb_sram_dp_param;

   localparam int DW    = 8;
   localparam int AW    = 12;
   localparam int BASE  = 256;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          rst;
   logic          we;
   logic          re;
   logic [AW-1:0] addr;
   logic [DW-1:0] di;
   logic [DW-1:0] dout;
   logic          ready;
   logic          oor;
   logic          perr;

   int checks = 0;
   int errors = 0;

   // Reference model: absolute address -> stored byte; missing key means 0.
   logic [7:0] ref_mem [int];
   logic [7:0] exp_dout;
   logic       exp_oor;
   logic       exp_perr;

   sram_dp_param #(.DW(DW), .AW(AW), .BASE(BASE), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .re    (re),
      .addr  (addr),
      .di    (di),
      .dout  (dout),
      .ready (ready),
      .oor   (oor),
      .perr  (perr)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit in_win(input int a);
      return (a >= BASE) && (a < BASE + DEPTH);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one access for one edge and update the reference model.
   task automatic apply(input logic w, input logic r, input int a, input logic [7:0] d);
      we   = w;
      re   = r;
      addr = AW'(a);
      di   = d;
      exp_oor  = (w || r) && !in_win(a);
      exp_perr = 1'b0;
      if (w && in_win(a)) ref_mem[a] = d;
      if (r) exp_dout = !in_win(a) ? 8'h00 : (ref_mem.exists(a) ? ref_mem[a] : 8'h00);
      tick();
      we = 1'b0;
      re = 1'b0;
   endtask

   task automatic release_reset();
      rst = 1'b0;
      ref_mem.delete();
      exp_dout = 8'h00;
   endtask

   // Counts edges until ready rises, bounded.
   task automatic wait_ready(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 5000) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({ready, dout, oor, perr} !== 11'd0) begin
         errors++;
         $display("FAIL reset_values ready=%b dout=%h oor=%b perr=%b required all 0", ready, dout, oor, perr);
      end
      release_reset();
      wait_ready(n);
      checks++;
      if (n !== DEPTH) begin
         errors++;
         $display("FAIL clear_length cycles=%0d required=%0d", n, DEPTH);
      end
      apply(1'b0, 1'b1, 'h100, 8'h00);
      checks++;
      if (dout !== 8'h00 || oor !== 1'b0) begin
         errors++;
         $display("FAIL read_after_clear dout=%h oor=%b required 00/0", dout, oor);
      end
   endtask

   task automatic test_write_read();
      apply(1'b1, 1'b0, 'h100, 8'hA5);
      apply(1'b1, 1'b0, 'h8FF, 8'h3C);
      checks++;
      if (oor !== 1'b0) begin
         errors++;
         $display("FAIL write_oor oor=%b required 0", oor);
      end
      apply(1'b0, 1'b1, 'h100, 8'h00);
      checks++;
      if (dout !== 8'hA5 || oor !== 1'b0) begin
         errors++;
         $display("FAIL read_0x100 dout=%h oor=%b required a5/0", dout, oor);
      end
      apply(1'b0, 1'b1, 'h8FF, 8'h00);
      checks++;
      if (dout !== 8'h3C || oor !== 1'b0) begin
         errors++;
         $display("FAIL read_0x8ff dout=%h oor=%b required 3c/0", dout, oor);
      end
   endtask

   task automatic test_out_of_range();
      apply(1'b1, 1'b0, 'h0FF, 8'hFF);
      checks++;
      if (oor !== 1'b1) begin
         errors++;
         $display("FAIL oor_write_below oor=%b required 1", oor);
      end
      apply(1'b0, 1'b1, 'h900, 8'h00);
      checks++;
      if (oor !== 1'b1 || dout !== 8'h00) begin
         errors++;
         $display("FAIL oor_read_above oor=%b dout=%h required 1/00", oor, dout);
      end
      tick();
      checks++;
      if (oor !== 1'b0) begin
         errors++;
         $display("FAIL oor_single_pulse oor=%b required 0", oor);
      end
      apply(1'b0, 1'b1, 'hFFF, 8'h00);
      checks++;
      if (oor !== 1'b1 || dout !== 8'h00) begin
         errors++;
         $display("FAIL oor_addr_wrap oor=%b dout=%h required 1/00", oor, dout);
      end
      apply(1'b0, 1'b1, 'h100, 8'h00);
      checks++;
      if (dout !== 8'hA5 || oor !== 1'b0) begin
         errors++;
         $display("FAIL readback_0x100 dout=%h oor=%b required a5/0", dout, oor);
      end
      // 0x0FF minus BASE truncates onto the last word; it must not alias there.
      apply(1'b0, 1'b1, 'h8FF, 8'h00);
      checks++;
      if (dout !== 8'h3C) begin
         errors++;
         $display("FAIL no_alias_0x8ff dout=%h required 3c", dout);
      end
   endtask

   task automatic test_write_first();
      apply(1'b1, 1'b1, 'h200, 8'h5A);
      checks++;
      if (dout !== 8'h5A || oor !== 1'b0 || perr !== 1'b0) begin
         errors++;
         $display("FAIL write_first dout=%h oor=%b perr=%b required 5a/0/0", dout, oor, perr);
      end
      tick();
      tick();
      checks++;
      if (dout !== 8'h5A) begin
         errors++;
         $display("FAIL dout_hold dout=%h required 5a", dout);
      end
      apply(0, 1, 'h200, 8'h00);
      checks++;
      if (dout !== 8'h5A) begin
         errors++;
         $display("FAIL write_first_stored dout=%h required 5a", dout);
      end
   endtask

   task automatic test_random();
      int a;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = BASE + int'($urandom_range(0, DEPTH - 1));
            6:                a = int'($urandom_range(BASE - 8, BASE + 7));
            7:                a = int'($urandom_range(BASE + DEPTH - 8, BASE + DEPTH + 7));
            8:                a = int'($urandom_range(0, (1 << AW) - 1));
            default:          a = (1 << AW) - 1;
         endcase
         apply(1'($urandom), 1'($urandom), a, 8'($urandom));
         checks++;
         if (dout !== exp_dout || oor !== exp_oor || perr !== exp_perr) begin
            errors++;
            $display("FAIL random[%0d] addr=%h dout=%h oor=%b perr=%b required %h/%b/%b",
                     i, a, dout, oor, perr, exp_dout, exp_oor, exp_perr);
         end
      end
   endtask

   task automatic test_clear_restart();
      int n;
      rst = 1'b1;
      tick();
      release_reset();
      repeat (1000) tick();
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_mid_clear ready=%b required 0", ready);
      end
      rst = 1'b1;
      tick();
      release_reset();
      repeat (10) tick();
      // Requests during CLEAR must be ignored; word 0 is already cleared here.
      we   = 1'b1;
      re   = 1'b1;
      addr = AW'('h100);
      di   = 8'h77;
      tick();
      we = 1'b0;
      re = 1'b0;
      checks++;
      if (dout !== 8'h00 || oor !== 1'b0 || ready !== 1'b0) begin
         errors++;
         $display("FAIL ignored_in_clear dout=%h oor=%b ready=%b required 00/0/0", dout, oor, ready);
      end
      wait_ready(n);
      checks++;
      if (n + 11 !== DEPTH) begin
         errors++;
         $display("FAIL restart_clear_length cycles=%0d required=%0d", n + 11, DEPTH);
      end
      apply(1'b0, 1'b1, 'h100, 8'h00);
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL cleared_0x100 dout=%h required 00", dout);
      end
      apply(1'b0, 1'b1, 'h8FF, 8'h00);
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL cleared_0x8ff dout=%h required 00", dout);
      end
      apply(1'b0, 1'b1, 'h200, 8'h00);
      checks++;
      if (dout !== 8'h00) begin
         errors++;
         $display("FAIL cleared_0x200 dout=%h required 00", dout);
      end
   endtask

`ifdef SRAM_PARITY_EN
   task automatic test_parity();
      apply(1'b1, 1'b0, 'h110, 8'h33);
      dut.mem[16] = dut.mem[16] ^ 9'h001;
      apply(1'b0, 1'b1, 'h110, 8'h00);
      checks++;
      if (perr !== 1'b1 || dout !== 8'h32) begin
         errors++;
         $display("FAIL parity_flag perr=%b dout=%h required 1/32", perr, dout);
      end
      tick();
      checks++;
      if (perr !== 1'b0) begin
         errors++;
         $display("FAIL parity_pulse perr=%b required 0", perr);
      end
      apply(1'b1, 1'b1, 'h110, 8'h44);
      checks++;
      if (perr !== 1'b0 || dout !== 8'h44) begin
         errors++;
         $display("FAIL parity_forward perr=%b dout=%h required 0/44", perr, dout);
      end
   endtask
`endif

   initial begin
      rst  = 1'b1;
      we   = 1'b0;
      re   = 1'b0;
      addr = '0;
      di   = '0;
      exp_dout = 8'h00;
      exp_oor  = 1'b0;
      exp_perr = 1'b0;
      test_reset();
      test_write_read();
      test_out_of_range();
      test_write_first();
`ifdef SRAM_PARITY_EN
      test_parity();
`endif
      test_random();
      test_clear_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
